mem_access_responder: RTL and testbench

//  Memory-side responder for the multicycle core's memory interface; serves the

---
 rtl/mem_access_responder_if.sv | 32 +++
 rtl/mem_access_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_access_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_responder_if.sv
// ============================================================================
// Module      : mem_access_responder_if
// Description : Request/response bundle between the core's memory port and
//               the memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_responder.sv
// ============================================================================
// Module      : mem_access_responder
// Description : Single-outstanding memory responder with programmable access
//               latency, word/half/byte lanes and error detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic                    clock,
    input  logic                    Reset,
    mem_access_responder_if.slave   bus
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] c_SIZE_WORD = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic                 r_write_q, w_write_d;
    logic [1:0]           r_size_q, w_size_d;
    logic                 r_signed_q, w_signed_d;
    logic [31:0]          r_addr_q, w_addr_d;
    logic [31:0]          r_wdata_q, w_wdata_d;
    logic                 r_ready_q, w_ready_d;
    logic                 r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0]          r_rsp_rdata_q, w_rsp_rdata_d;
    logic                 r_rsp_err_q, w_rsp_err_d;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_out_of_range;
    logic                 w_misaligned;
    logic                 w_err;
    logic [31:0]          w_old;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;
    logic [31:0]          w_merged;
    logic                 w_do_access;
    logic                 w_mem_we;

    // Decode of the captured request; only consumed on the access edge.
    assign w_idx          = r_addr_q[c_IDX_W+1:2];
    assign w_out_of_range = |r_addr_q[31:c_IDX_W+2];
    assign w_misaligned   = ((r_size_q == c_SIZE_WORD) && (r_addr_q[1:0] != 2'b00)) ||
                            ((r_size_q == c_SIZE_HALF) && r_addr_q[0]);
    assign w_err          = (r_size_q == 2'b11) || w_out_of_range || w_misaligned;
    assign w_old          = r_mem[w_idx];
    assign w_byte         = w_old[{r_addr_q[1:0], 3'b000} +: 8];
    assign w_half         = r_addr_q[1] ? w_old[31:16] : w_old[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_size_q)
            c_SIZE_WORD: w_load = w_old;
            c_SIZE_HALF: w_load = {{16{r_signed_q & w_half[15]}}, w_half};
            c_SIZE_BYTE: w_load = {{24{r_signed_q & w_byte[7]}}, w_byte};
            default:     w_load = 32'd0;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the existing word.
    always_comb begin
        w_merged = w_old;
        case (r_size_q)
            c_SIZE_WORD: w_merged = r_wdata_q;
            c_SIZE_HALF: w_merged[{r_addr_q[1], 4'b0000} +: 16] = r_wdata_q[15:0];
            c_SIZE_BYTE: w_merged[{r_addr_q[1:0], 3'b000} +: 8] = r_wdata_q[7:0];
            default:     w_merged = w_old;
        endcase
    end

    assign w_do_access = (r_state_q == ST_BUSY) && (r_cnt_q == '0);
    assign w_mem_we    = w_do_access && r_write_q && !w_err;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_write_d     = r_write_q;
        w_size_d      = r_size_q;
        w_signed_d    = r_signed_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_rsp_valid_d = 1'b0;
        w_rsp_rdata_d = 32'd0;
        w_rsp_err_d   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_d  = ST_BUSY;
                    w_cnt_d    = c_CNT_W'(LATENCY - 1);
                    w_write_d  = bus.req_write;
                    w_size_d   = bus.req_size;
                    w_signed_d = bus.req_signed;
                    w_addr_d   = bus.req_addr;
                    w_wdata_d  = bus.req_wdata;
                end
            end
            ST_BUSY: begin
                if (r_cnt_q == '0) begin
                    w_state_d     = ST_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = w_err;
                    w_rsp_rdata_d = (w_err || r_write_q) ? 32'd0 : w_load;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_ready_d = (w_state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_write_q     <= 1'b0;
            r_size_q      <= 2'b00;
            r_signed_q    <= 1'b0;
            r_addr_q      <= 32'd0;
            r_wdata_q     <= 32'd0;
            r_ready_q     <= 1'b1;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= 32'd0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_write_q     <= w_write_d;
            r_size_q      <= w_size_d;
            r_signed_q    <= w_signed_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_ready_q     <= w_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    // Storage is deliberately left out of reset; a reset edge only blocks the commit.
    always_ff @(posedge clock) begin
        if (w_mem_we && !Reset) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign bus.req_ready = r_ready_q;
    assign bus.rsp_valid = r_rsp_valid_q;
    assign bus.rsp_rdata = r_rsp_rdata_q;
    assign bus.rsp_err   = r_rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_responder.sv
// ============================================================================
// Module      : tb_mem_access_responder
// Description : Scoreboard bench for mem_access_responder (LATENCY 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_responder;

    localparam int LAT = 2;

    logic clock = 1'b0;
    logic Reset;
    always #5 clock = ~clock;

    mem_access_responder_if bus ();
    mem_access_responder_if bus1 ();

    mem_access_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) u_dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    mem_access_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response pulse and checks timing.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.rsp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 required none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
                    chk({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
                    chk({e.name, "_latency"}, cyc - e.acc, LAT);
                end
                chk("ready_during_resp", {31'd0, bus.req_ready}, 32'd0);
            end else begin
                chk("idle_rdata_zero", bus.rsp_rdata, 32'd0);
                chk("idle_err_zero", {31'd0, bus.rsp_err}, 32'd0);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input string nm, input bit expect_rsp);
        int t;
        t = 0;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept_timeout: got req_ready=%b required 1", nm, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        if (expect_rsp) sbq.push_back('{er, ee, cyc + 1, nm});
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending responses required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic lat1_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] er, input string nm);
        int acc;
        int t;
        @(negedge clock);
        chk({nm, "_ready"}, {31'd0, bus1.req_ready}, 32'd1);
        bus1.req_valid = 1'b1;
        bus1.req_write = wr;
        bus1.req_size  = 2'b00;
        bus1.req_addr  = a;
        bus1.req_wdata = wd;
        acc = cyc + 1;
        @(posedge clock);
        #1 bus1.req_valid = 1'b0;
        t = 0;
        @(negedge clock);
        while (bus1.rsp_valid !== 1'b1 && t < 10) begin
            @(negedge clock);
            t++;
        end
        chk({nm, "_latency"}, cyc - acc, 1);
        chk({nm, "_rdata"}, bus1.rsp_rdata, er);
        @(negedge clock);
        chk({nm, "_pulse_len"}, {31'd0, bus1.rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'b00;
        bus1.req_signed = 1'b0; bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Basic word store / load
        issue(1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10", 1);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10", 1);

        // Byte / half lanes and extension
        issue(1, 2'b10, 0, 32'h11, 32'h000000A5, 32'h0, 0, "sb_11", 1);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'hDEADA5EF, 0, "lw_10_b", 1);
        issue(0, 2'b10, 1, 32'h11, 32'h0, 32'hFFFFFFA5, 0, "lb_11", 1);
        issue(0, 2'b10, 0, 32'h11, 32'h0, 32'h000000A5, 0, "lbu_11", 1);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, "lh_12", 1);
        issue(0, 2'b01, 0, 32'h10, 32'h0, 32'h0000A5EF, 0, "lhu_10", 1);
        issue(1, 2'b00, 0, 32'h14, 32'h11223344, 32'h0, 0, "sw_14", 1);
        issue(1, 2'b01, 0, 32'h16, 32'hFFFFBEEF, 32'h0, 0, "sh_16", 1);
        issue(0, 2'b00, 0, 32'h14, 32'h0, 32'hBEEF3344, 0, "lw_14", 1);
        issue(0, 2'b10, 0, 32'h17, 32'h0, 32'h000000BE, 0, "lbu_17", 1);
        issue(0, 2'b10, 1, 32'h17, 32'h0, 32'hFFFFFFBE, 0, "lb_17", 1);
        issue(0, 2'b10, 1, 32'h14, 32'h0, 32'h00000044, 0, "lb_14", 1);
        issue(1, 2'b00, 0, 32'hFC, 32'h55AA55AA, 32'h0, 0, "sw_fc", 1);
        issue(0, 2'b00, 0, 32'hFC, 32'h0, 32'h55AA55AA, 0, "lw_fc", 1);
        issue(1, 2'b00, 0, 32'h00, 32'h0BADF00D, 32'h0, 0, "sw_00", 1);
        issue(1, 2'b00, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, "sw_20", 1);

        // Error cases must leave storage untouched
        issue(0, 2'b00, 0, 32'h12, 32'h0, 32'h0, 1, "lw_mis", 1);
        issue(1, 2'b01, 0, 32'h13, 32'hFFFFFFFF, 32'h0, 1, "sh_mis", 1);
        issue(1, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, "size3_w", 1);
        issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, "size3_r", 1);
        issue(1, 2'b00, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1, "sw_oor", 1);
        issue(0, 2'b00, 0, 32'h100, 32'h0, 32'h0, 1, "lw_oor", 1);
        issue(0, 2'b00, 0, 32'h00, 32'h0, 32'h0BADF00D, 0, "lw_00_chk", 1);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'hDEADA5EF, 0, "lw_10_chk", 1);
        drain();

        // Continuous request stream
        begin
            int last;
            int nacc;
            last = -1;
            nacc = 0;
            @(negedge clock);
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b00;
            bus.req_signed = 1'b0; bus.req_addr = 32'h10;
            for (int i = 0; i < 16; i++) begin
                if (bus.req_ready === 1'b1) begin
                    if (last >= 0) chk("stream_spacing", cyc + 1 - last, LAT + 2);
                    last = cyc + 1;
                    nacc++;
                    sbq.push_back('{32'hDEADA5EF, 1'b0, cyc + 1, "stream_lw"});
                end
                @(negedge clock);
            end
            bus.req_valid = 1'b0;
            chk("stream_accepts", nacc, 4);
        end
        drain();

        // Reset while a store is in flight
        issue(1, 2'b00, 0, 32'h20, 32'h00001234, 32'h0, 0, "sw_reset", 0);
        @(negedge clock);
        Reset = 1'b1;
        @(negedge clock);
        Reset = 1'b0;
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        repeat (6) @(negedge clock);
        issue(0, 2'b00, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, "lw_20_after_reset", 1);
        drain();

        // LATENCY=1 instance
        lat1_txn(1, 32'h40, 32'h89ABCDEF, 32'h0, "lat1_sw");
        lat1_txn(0, 32'h40, 32'h0, 32'h89ABCDEF, "lat1_lw");

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
